// File: rtl/mux_2to1.sv
// mux_2to1: parameterised 2:1 data selector with a one-cycle registered copy and a select-change pulse.
// Optional feature macro MUX_2TO1_STATS_EN adds a saturating select-switch counter (switch_cnt).
module mux_2to1 #(
  parameter int WIDTH     = 1,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     data0,
  input  logic [WIDTH-1:0]     data1,
  input  logic                 sel,
  output logic [WIDTH-1:0]     out,
  output logic [WIDTH-1:0]     out_q,
  output logic                 sel_chg
`ifdef MUX_2TO1_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] switch_cnt
`endif
);

  logic sel_q_r;
  logic sel_diff_s;

  if (WIDTH < 1 || CNT_WIDTH < 1) begin : g_param_check
    $error("mux_2to1: WIDTH and CNT_WIDTH must be at least 1");
  end

  // Selected source goes straight through; it stays valid while rst_n is low.
  always_comb begin
    if (sel) begin
      out = data1;
    end else begin
      out = data0;
    end
  end

  assign sel_diff_s = (sel != sel_q_r);

  // Registered copy of out plus the previous select and its change pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= {WIDTH{1'b0}};
      sel_q_r <= 1'b0;
      sel_chg <= 1'b0;
    end else begin
      out_q   <= out;
      sel_q_r <= sel;
      sel_chg <= sel_diff_s;
    end
  end

`ifdef MUX_2TO1_STATS_EN
  logic [CNT_WIDTH-1:0] switch_cnt_r;

  // Count select changes, holding at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      switch_cnt_r <= {CNT_WIDTH{1'b0}};
    end else if (sel_diff_s && (switch_cnt_r != {CNT_WIDTH{1'b1}})) begin
      switch_cnt_r <= switch_cnt_r + CNT_WIDTH'(1'b1);
    end else begin
      switch_cnt_r <= switch_cnt_r;
    end
  end

  assign switch_cnt = switch_cnt_r;
`endif

endmodule

// File: tb/tb_mux_2to1.sv
// Scoreboard bench for mux_2to1: a WIDTH=1 instance (CNT_WIDTH=2) and a WIDTH=8 instance share clk/rst_n/sel.
// Stimulus pushes expectations into a queue; a separate monitor pops and compares them.
`timescale 1ns/1ps
module tb_mux_2to1;

  localparam int K_OUT1 = 0;
  localparam int K_OUTQ1 = 1;
  localparam int K_CHG1 = 2;
  localparam int K_OUT8 = 3;
  localparam int K_CNT = 4;

  typedef struct {
    string      name;
    int         kind;
    logic [7:0] exp;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       sel;
  logic [0:0] d0_1, d1_1, out_1, outq_1;
  logic       chg_1;
  logic [7:0] d0_8, d1_8, out_8, outq_8;
  logic       chg_8;
`ifdef MUX_2TO1_STATS_EN
  logic [1:0] cnt_1;
  logic [7:0] cnt_8;
`endif

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  mux_2to1 #(.WIDTH(1), .CNT_WIDTH(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .data0(d0_1), .data1(d1_1), .sel(sel),
    .out(out_1), .out_q(outq_1), .sel_chg(chg_1)
`ifdef MUX_2TO1_STATS_EN
    , .switch_cnt(cnt_1)
`endif
  );

  mux_2to1 #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .data0(d0_8), .data1(d1_8), .sel(sel),
    .out(out_8), .out_q(outq_8), .sel_chg(chg_8)
`ifdef MUX_2TO1_STATS_EN
    , .switch_cnt(cnt_8)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: pops every pending expectation and compares it against the live DUT output.
  initial begin : monitor
    exp_t       e;
    logic [7:0] act;
    forever begin
      while (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        act = 8'h00;
        case (e.kind)
          K_OUT1:  act = {7'b0, out_1};
          K_OUTQ1: act = {7'b0, outq_1};
          K_CHG1:  act = {7'b0, chg_1};
          K_OUT8:  act = out_8;
`ifdef MUX_2TO1_STATS_EN
          K_CNT:   act = {6'b0, cnt_1};
`endif
          default: act = 8'hxx;
        endcase
        n_checks++;
        if (act === e.exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", e.name, act, e.exp);
      end
      #1;
    end
  end

  task automatic expect_val(input string name, input int kind, input logic [7:0] exp);
    exp_t e;
    e.name = name;
    e.kind = kind;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  // Wait (bounded) for the monitor to consume every queued expectation.
  task automatic drain();
    int guard = 0;
    while (sb_q.size() != 0 && guard < 5) begin
      #1;
      guard++;
    end
    if (sb_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic reg_check(input string tag, input logic oq, input logic chg);
    expect_val({tag, "_out_q"}, K_OUTQ1, {7'b0, oq});
    expect_val({tag, "_sel_chg"}, K_CHG1, {7'b0, chg});
    drain();
  endtask

  task automatic cnt_check(input string tag, input logic [1:0] c);
`ifdef MUX_2TO1_STATS_EN
    expect_val({tag, "_switch_cnt"}, K_CNT, {6'b0, c});
    drain();
`else
    if (tag.len() == 0 && c == 2'd3) $display("note: empty tag");
`endif
  endtask

  logic [3:0] tt [8];

  initial begin : stimulus
    rst_n = 1'b1; sel = 1'b0;
    d0_1 = 1'b0; d1_1 = 1'b0; d0_8 = 8'h00; d1_8 = 8'h00;
    #2 rst_n = 1'b0;

    @(negedge clk);
    reg_check("reset", 1'b0, 1'b0);
    cnt_check("reset", 2'd0);

    // Truth table {d0,d1,sel,expected}, run while in reset to show out is unaffected.
    tt[0] = 4'b0010; tt[1] = 4'b0100; tt[2] = 4'b0111; tt[3] = 4'b1001;
    tt[4] = 4'b1010; tt[5] = 4'b1101; tt[6] = 4'b1111; tt[7] = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      d0_1 = tt[i][3]; d1_1 = tt[i][2]; sel = tt[i][1];
      #1 expect_val($sformatf("tt%0d_out", i), K_OUT1, {7'b0, tt[i][0]});
      drain();
    end

    @(negedge clk);
    d0_8 = 8'h5A; d1_8 = 8'hC3; sel = 1'b0;
    #1 expect_val("w8_sel0_out", K_OUT8, 8'h5A);
    drain();
    sel = 1'b1;
    #1 expect_val("w8_sel1_out", K_OUT8, 8'hC3);
    drain();

    // Release reset with sel=0, d0=0, d1=1.
    @(negedge clk);
    sel = 1'b0; d0_1 = 1'b0; d1_1 = 1'b1; rst_n = 1'b1;

    @(negedge clk);
    reg_check("rel", 1'b0, 1'b0);
    cnt_check("rel", 2'd0);
    sel = 1'b1;
    #1 expect_val("sel1_out", K_OUT1, 8'h01);
    drain();

    @(negedge clk);
    reg_check("sel1", 1'b1, 1'b1);
    cnt_check("chg1", 2'd1);
    sel = 1'b0;
    #1 expect_val("sel0_out", K_OUT1, 8'h00);
    drain();

    @(negedge clk);
    reg_check("sel0", 1'b0, 1'b1);
    cnt_check("chg2", 2'd2);
    @(negedge clk); reg_check("hold0_a", 1'b0, 1'b0);
    @(negedge clk); reg_check("hold0_b", 1'b0, 1'b0);
    sel = 1'b1;

    @(negedge clk); reg_check("rise", 1'b1, 1'b1);
    cnt_check("chg3", 2'd3);
    @(negedge clk); reg_check("rise_after", 1'b1, 1'b0);

    for (int i = 0; i < 4; i++) begin
      sel = ~sel;
      @(negedge clk);
      reg_check($sformatf("toggle%0d", i), sel, 1'b1);
      if (i < 2) cnt_check($sformatf("sat%0d", i), 2'd3);
    end

    // sel now 1: a data-only change must not raise sel_chg.
    d0_1 = 1'b1;
    @(negedge clk);
    reg_check("data_only", 1'b1, 1'b0);

    #1 rst_n = 1'b0;
    #1;
    expect_val("arst_out", K_OUT1, 8'h01);
    reg_check("arst", 1'b0, 1'b0);
    cnt_check("arst", 2'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before 100us");
    $fatal(1);
  end

endmodule
